// File: rtl/cfi_landing_pad_ctrl_pkg.sv
// rtl/cfi_landing_pad_ctrl_pkg.sv - shared types and register map for the CFI landing-pad controller
package cfi_landing_pad_ctrl_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;

  // Register map
  localparam logic [1:0] CFI_REG_CTRL    = 2'd0;
  localparam logic [1:0] CFI_REG_STATUS  = 2'd1;
  localparam logic [1:0] CFI_REG_COUNT   = 2'd2;
  localparam logic [1:0] CFI_REG_LAST_PC = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    EXPECT_LP,
    REPORT
  } cfi_state_e;

  typedef enum logic [2:0] {
    NONE,
    CALL,
    RET,
    JUMP,
    LP
  } cfi_class_t;

  // Reduced view of the commit-stage scoreboard entry: only the fields the checker needs
  typedef enum logic [2:0] {
    OP_OTHER,
    OP_ADD,
    OP_ADDW,
    OP_JALR
  } fu_op_e;

  typedef struct packed {
    logic valid;
  } exception_t;

  typedef struct packed {
    fu_op_e     op;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic [63:0] pc;
    exception_t ex;
  } scoreboard_entry_t;

  // Field order mirrors CTRL bit layout: [8:4] lp_reg, [3] chk_ret, [2] chk_call, [1] trap_en, [0] en
  typedef struct packed {
    logic [4:0] lp_reg;
    logic       chk_ret;
    logic       chk_call;
    logic       trap_en;
    logic       en;
  } cfi_ctrl_t;

  function automatic logic [31:0] cfi_ctrl_to_word(input cfi_ctrl_t c);
    return {23'd0, c};
  endfunction

endpackage

// File: rtl/cfi_landing_pad_ctrl_if.sv
// rtl/cfi_landing_pad_ctrl_if.sv - commit, register and trap signals of the CFI controller
interface cfi_landing_pad_ctrl_if #(
  parameter int unsigned NR_PORTS = cfi_landing_pad_ctrl_pkg::NR_COMMIT_PORTS
);
  import cfi_landing_pad_ctrl_pkg::*;

  scoreboard_entry_t [NR_PORTS-1:0] commit_instr_i;
  logic [NR_PORTS-1:0]              commit_ack_i;
  logic                             cfg_we_i;
  logic [1:0]                       cfg_addr_i;
  logic [31:0]                      cfg_wdata_i;
  logic [31:0]                      cfg_rdata_o;
  logic                             cfi_exc_req_o;
  logic                             cfi_exc_ack_i;
  logic [63:0]                      cfi_exc_pc_o;

  // Environment side: commit stage, register master and exception logic
  modport master (
    output commit_instr_i, commit_ack_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfi_exc_ack_i,
    input  cfg_rdata_o, cfi_exc_req_o, cfi_exc_pc_o
  );

  // Controller side
  modport slave (
    input  commit_instr_i, commit_ack_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfi_exc_ack_i,
    output cfg_rdata_o, cfi_exc_req_o, cfi_exc_pc_o
  );

endinterface

// File: rtl/cfi_landing_pad_ctrl_classifier.sv
// rtl/cfi_landing_pad_ctrl_classifier.sv - classifies one committed entry for landing-pad checking
module cfi_landing_pad_ctrl_classifier
  import cfi_landing_pad_ctrl_pkg::*;
(
  input  fu_op_e     op_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] lp_reg_i,
  input  logic       chk_call_i,
  input  logic       chk_ret_i,
  output cfi_class_t class_o,
  output logic       checked_o
);

  // Call/ret/jump split of JALR; only JALRs can be checked, jumps always are
  always_comb begin
    class_o   = NONE;
    checked_o = 1'b0;
    if (op_i == OP_JALR) begin
      if (rd_i == 5'd1) begin
        class_o   = CALL;
        checked_o = chk_call_i;
      end else if (rd_i == 5'd0 && rs1_i == 5'd1) begin
        class_o   = RET;
        checked_o = chk_ret_i;
      end else begin
        class_o   = JUMP;
        checked_o = 1'b1;
      end
    end else if (op_i == OP_ADDW && rd_i == 5'd0 && rs1_i == lp_reg_i) begin
      class_o = LP;
    end
  end

endmodule

// File: rtl/cfi_landing_pad_ctrl.sv
// rtl/cfi_landing_pad_ctrl.sv - commit-stage landing-pad checker with violation counter and trap request
module cfi_landing_pad_ctrl
  import cfi_landing_pad_ctrl_pkg::*;
#(
  parameter int unsigned NR_PORTS   = NR_COMMIT_PORTS,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [4:0]  LP_REG_RST = 5'd1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  cfi_landing_pad_ctrl_if.slave bus
);

  localparam cfi_ctrl_t CTRL_RST = '{
    lp_reg:   LP_REG_RST,
    chk_ret:  1'b1,
    chk_call: 1'b1,
    trap_en:  1'b0,
    en:       1'b0
  };

  cfi_ctrl_t            ctrl_q, ctrl_d;
  cfi_state_e           state_q;
  logic                 expect_q;
  logic [63:0]          jalr_pc_q;
  logic                 req_q;
  logic [63:0]          exc_pc_q;
  logic                 sticky_q, sticky_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]          last_pc_q, last_pc_d;

  cfi_class_t           cls [NR_PORTS];
  logic [NR_PORTS-1:0]  checked;

  logic                 scan_expect;
  logic [63:0]          scan_pc;
  logic                 viol;
  logic [63:0]          viol_pc;

  logic                 wr_ctrl, wr_status, wr_count;
  logic                 unused_wdata;

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_cls
    cfi_landing_pad_ctrl_classifier u_cls (
      .op_i       (bus.commit_instr_i[g].op),
      .rs1_i      (bus.commit_instr_i[g].rs1),
      .rd_i       (bus.commit_instr_i[g].rd),
      .lp_reg_i   (ctrl_q.lp_reg),
      .chk_call_i (ctrl_q.chk_call),
      .chk_ret_i  (ctrl_q.chk_ret),
      .class_o    (cls[g]),
      .checked_o  (checked[g])
    );
  end

  // Walk acked entries in program order; the first entry after a checked JALR must be a landing pad
  always_comb begin
    scan_expect = expect_q;
    scan_pc     = jalr_pc_q;
    viol        = 1'b0;
    viol_pc     = '0;
    if (!ctrl_q.en) begin
      scan_expect = 1'b0;
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        if (bus.commit_ack_i[i]) begin
          if (bus.commit_instr_i[i].ex.valid) begin
            // Trap/interrupt redirect: the pending JALR target is abandoned, not violated
            scan_expect = 1'b0;
          end else begin
            if (scan_expect) begin
              if (cls[i] != LP && !viol) begin
                viol    = 1'b1;
                viol_pc = scan_pc;
              end
              scan_expect = 1'b0;
            end
            if (checked[i]) begin
              scan_expect = 1'b1;
              scan_pc     = bus.commit_instr_i[i].pc;
            end
          end
        end
      end
    end
  end

  assign wr_ctrl      = bus.cfg_we_i && (bus.cfg_addr_i == CFI_REG_CTRL);
  assign wr_status    = bus.cfg_we_i && (bus.cfg_addr_i == CFI_REG_STATUS);
  assign wr_count     = bus.cfg_we_i && (bus.cfg_addr_i == CFI_REG_COUNT);
  assign unused_wdata = ^bus.cfg_wdata_i[31:9];

  // Trap FSM: a violation while already reporting never re-raises req nor moves exc_pc
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      expect_q  <= 1'b0;
      jalr_pc_q <= '0;
      req_q     <= 1'b0;
      exc_pc_q  <= '0;
    end else begin
      expect_q  <= scan_expect;
      jalr_pc_q <= scan_pc;
      case (state_q)
        REPORT: begin
          if (req_q && bus.cfi_exc_ack_i) begin
            req_q   <= 1'b0;
            state_q <= scan_expect ? EXPECT_LP : IDLE;
          end
        end
        default: begin
          if (viol && ctrl_q.trap_en) begin
            state_q  <= REPORT;
            req_q    <= 1'b1;
            exc_pc_q <= viol_pc;
          end else begin
            state_q <= scan_expect ? EXPECT_LP : IDLE;
          end
        end
      endcase
    end
  end

  // Register next-state: hardware set beats software clear, clear-on-write beats increment
  always_comb begin
    ctrl_d    = wr_ctrl ? cfi_ctrl_t'(bus.cfg_wdata_i[8:0]) : ctrl_q;
    sticky_d  = viol | (sticky_q & ~(wr_status & bus.cfg_wdata_i[0]));
    ovf_d     = (viol && state_q == REPORT) | (ovf_q & ~(wr_status & bus.cfg_wdata_i[1]));
    last_pc_d = viol ? viol_pc[31:0] : last_pc_q;
    count_d   = count_q;
    if (wr_count) begin
      count_d = '0;
    end else if (viol && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  // Register file state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= CTRL_RST;
      sticky_q  <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      sticky_q  <= sticky_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Combinational register read
  always_comb begin
    bus.cfg_rdata_o = '0;
    case (bus.cfg_addr_i)
      CFI_REG_CTRL:    bus.cfg_rdata_o = cfi_ctrl_to_word(ctrl_q);
      CFI_REG_STATUS:  bus.cfg_rdata_o = {29'd0, req_q, ovf_q, sticky_q};
      CFI_REG_COUNT:   bus.cfg_rdata_o = 32'(count_q);
      CFI_REG_LAST_PC: bus.cfg_rdata_o = last_pc_q;
      default:         bus.cfg_rdata_o = '0;
    endcase
  end

  assign bus.cfi_exc_req_o = req_q;
  assign bus.cfi_exc_pc_o  = exc_pc_q;

endmodule

// File: tb/tb_cfi_landing_pad_ctrl.sv
// tb/tb_cfi_landing_pad_ctrl.sv - self-checking bench for cfi_landing_pad_ctrl
module tb_cfi_landing_pad_ctrl;
  import cfi_landing_pad_ctrl_pkg::*;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cfi_landing_pad_ctrl_if #(.NR_PORTS(NP)) bus ();

  cfi_landing_pad_ctrl #(
    .NR_PORTS   (NP),
    .CNT_WIDTH  (16),
    .LP_REG_RST (5'd1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Reference model state
  logic        m_en, m_trap, m_chk_call, m_chk_ret;
  logic [4:0]  m_lp;
  logic        m_expect;
  logic [63:0] m_jpc;
  logic        m_req;
  logic [63:0] m_exc_pc;
  int          m_count;
  logic        m_sticky, m_ovf;
  logic [31:0] m_last;

  task automatic model_reset();
    m_en = 1'b0; m_trap = 1'b0; m_chk_call = 1'b1; m_chk_ret = 1'b1; m_lp = 5'd1;
    m_expect = 1'b0; m_jpc = '0; m_req = 1'b0; m_exc_pc = '0;
    m_count = 0; m_sticky = 1'b0; m_ovf = 1'b0; m_last = '0;
  endtask

  function automatic logic needs_pad(input scoreboard_entry_t e);
    if (e.op != OP_JALR) return 1'b0;
    if (e.rd == 5'd1) return m_chk_call;
    if (e.rd == 5'd0 && e.rs1 == 5'd1) return m_chk_ret;
    return 1'b1;
  endfunction

  function automatic logic is_pad(input scoreboard_entry_t e);
    return e.op == OP_ADDW && e.rd == 5'd0 && e.rs1 == m_lp;
  endfunction

  // Advance the model by one clock using the inputs present at this edge
  task automatic model_step();
    scoreboard_entry_t retired[$];
    scoreboard_entry_t e;
    logic        viol;
    logic [63:0] vpc;
    logic        was_req;
    logic        we_ctrl, we_stat, we_cnt;
    viol = 1'b0; vpc = '0; was_req = m_req;
    for (int i = 0; i < NP; i++)
      if (bus.commit_ack_i[i]) retired.push_back(bus.commit_instr_i[i]);
    if (!m_en) m_expect = 1'b0;
    else begin
      foreach (retired[k]) begin
        e = retired[k];
        if (e.ex.valid) m_expect = 1'b0;
        else begin
          if (m_expect && !is_pad(e) && !viol) begin viol = 1'b1; vpc = m_jpc; end
          m_expect = 1'b0;
          if (needs_pad(e)) begin m_expect = 1'b1; m_jpc = e.pc; end
        end
      end
    end
    we_ctrl = bus.cfg_we_i && bus.cfg_addr_i == 2'd0;
    we_stat = bus.cfg_we_i && bus.cfg_addr_i == 2'd1;
    we_cnt  = bus.cfg_we_i && bus.cfg_addr_i == 2'd2;
    if (was_req) begin
      if (bus.cfi_exc_ack_i) m_req = 1'b0;
    end else if (viol && m_trap) begin
      m_req = 1'b1; m_exc_pc = vpc;
    end
    if (viol && was_req) m_ovf = 1'b1;
    else if (we_stat && bus.cfg_wdata_i[1]) m_ovf = 1'b0;
    if (viol) m_sticky = 1'b1;
    else if (we_stat && bus.cfg_wdata_i[0]) m_sticky = 1'b0;
    if (we_cnt) m_count = 0;
    else if (viol && m_count < 65535) m_count++;
    if (viol) m_last = vpc[31:0];
    if (we_ctrl) begin
      m_en = bus.cfg_wdata_i[0]; m_trap = bus.cfg_wdata_i[1];
      m_chk_call = bus.cfg_wdata_i[2]; m_chk_ret = bus.cfg_wdata_i[3];
      m_lp = bus.cfg_wdata_i[8:4];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.cfg_addr_i = a;
    #1;
    v = bus.cfg_rdata_o;
  endtask

  // Compare every visible output and register against the model (takes 4 time units)
  task automatic check_all();
    logic [31:0] v;
    chk("req", 64'(bus.cfi_exc_req_o), 64'(m_req));
    if (m_req) chk("exc_pc", bus.cfi_exc_pc_o, m_exc_pc);
    rd(2'd0, v); chk("ctrl", 64'(v), 64'({23'd0, m_lp, m_chk_ret, m_chk_call, m_trap, m_en}));
    rd(2'd1, v); chk("status", 64'(v), 64'({29'd0, m_req, m_ovf, m_sticky}));
    rd(2'd2, v); chk("count", 64'(v), 64'(m_count));
    rd(2'd3, v); chk("last_pc", 64'(v), 64'(m_last));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic clear_commits();
    bus.commit_ack_i   = '0;
    bus.commit_instr_i = '0;
  endtask

  task automatic put(input int p, input fu_op_e op, input logic [4:0] rd_, input logic [4:0] rs1,
                     input logic [63:0] pc, input logic exv);
    bus.commit_ack_i[p]          = 1'b1;
    bus.commit_instr_i[p].op     = op;
    bus.commit_instr_i[p].rd     = rd_;
    bus.commit_instr_i[p].rs1    = rs1;
    bus.commit_instr_i[p].pc     = pc;
    bus.commit_instr_i[p].ex.valid = exv;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = a; bus.cfg_wdata_i = d;
    tick();
    bus.cfg_we_i = 1'b0;
  endtask

  function automatic scoreboard_entry_t rand_entry();
    scoreboard_entry_t e;
    int k;
    e = '0;
    k = $urandom_range(0, 9);
    e.pc = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4;
    e.ex.valid = ($urandom_range(0, 15) == 0);
    case (k)
      0, 1: begin e.op = OP_JALR; e.rd = 5'd1; e.rs1 = 5'($urandom_range(0, 31)); end
      2:    begin e.op = OP_JALR; e.rd = 5'd0; e.rs1 = 5'd1; end
      3:    begin e.op = OP_JALR; e.rd = 5'($urandom_range(0, 31)); e.rs1 = 5'($urandom_range(0, 31)); end
      4, 5, 6: begin e.op = OP_ADDW; e.rd = 5'd0; e.rs1 = m_lp; end
      7:    begin e.op = OP_ADDW; e.rd = 5'($urandom_range(0, 3)); e.rs1 = 5'($urandom_range(0, 31)); end
      8:    begin e.op = OP_ADD; e.rd = 5'd0; e.rs1 = m_lp; end
      default: begin e.op = OP_OTHER; e.rd = 5'($urandom_range(0, 31)); e.rs1 = 5'($urandom_range(0, 31)); end
    endcase
    return e;
  endfunction

  initial begin
    logic [31:0] v;
    int n;
    int r;
    clear_commits();
    bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0; bus.cfi_exc_ack_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rd(2'd0, v); chk("rst_ctrl_value", 64'(v), 64'h1C);
    @(negedge clk);
    rst_n = 1'b1;

    // Call immediately followed by its landing pad in the same cycle
    cfg_write(2'd0, 32'h1F);
    put(0, OP_JALR, 5'd1, 5'd5, 64'h8000_0100, 1'b0);
    put(1, OP_ADDW, 5'd0, 5'd1, 64'h8000_0104, 1'b0);
    tick(); clear_commits(); tick();
    chk("t1_req", 64'(bus.cfi_exc_req_o), 64'd0);
    rd(2'd2, v); chk("t1_count", 64'(v), 64'd0);
    chk("t1_state", 64'(dut.state_q), 64'(IDLE));

    // Jump, idle cycle, non-pad -> trap at the following cycle
    put(0, OP_JALR, 5'd0, 5'd5, 64'h8000_0200, 1'b0);
    tick(); clear_commits(); tick();
    put(0, OP_ADD, 5'd3, 5'd4, 64'h8000_0204, 1'b0);
    tick(); clear_commits();
    chk("t2_req", 64'(bus.cfi_exc_req_o), 64'd1);
    chk("t2_exc_pc", bus.cfi_exc_pc_o, 64'h8000_0200);
    rd(2'd2, v); chk("t2_count", 64'(v), 64'd1);
    rd(2'd1, v); chk("t2_sticky", 64'(v[0]), 64'd1);

    // Second violation while reporting, ack withheld for 4 cycles
    put(0, OP_JALR, 5'd0, 5'd7, 64'h8000_0300, 1'b0);
    put(1, OP_ADD, 5'd3, 5'd4, 64'h8000_0304, 1'b0);
    tick(); clear_commits();
    repeat (3) tick();
    chk("t3_req", 64'(bus.cfi_exc_req_o), 64'd1);
    chk("t3_exc_pc", bus.cfi_exc_pc_o, 64'h8000_0200);
    rd(2'd2, v); chk("t3_count", 64'(v), 64'd2);
    rd(2'd1, v); chk("t3_ovf", 64'(v[1]), 64'd1);
    rd(2'd3, v); chk("t3_last_pc", 64'(v), 64'h8000_0300);
    bus.cfi_exc_ack_i = 1'b1;
    tick();
    bus.cfi_exc_ack_i = 1'b0;
    chk("t3_req_drop", 64'(bus.cfi_exc_req_o), 64'd0);

    // trap_en=0, chk_ret=0: unchecked ret, then a checked jump
    cfg_write(2'd2, 32'h0);
    cfg_write(2'd0, 32'h15);
    put(0, OP_JALR, 5'd0, 5'd1, 64'h8000_0400, 1'b0); tick(); clear_commits();
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0404, 1'b0); tick(); clear_commits();
    rd(2'd2, v); chk("t4_ret_count", 64'(v), 64'd0);
    put(0, OP_JALR, 5'd0, 5'd6, 64'h8000_0500, 1'b0); tick(); clear_commits();
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0504, 1'b0); tick(); clear_commits();
    rd(2'd2, v); chk("t4_jump_count", 64'(v), 64'd1);
    chk("t4_req", 64'(bus.cfi_exc_req_o), 64'd0);

    // Exception redirect after a call, then disabling in EXPECT_LP
    cfg_write(2'd0, 32'h1F);
    put(0, OP_JALR, 5'd1, 5'd2, 64'h8000_0600, 1'b0); tick(); clear_commits();
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0604, 1'b1); tick(); clear_commits();
    chk("t5_exc_state", 64'(dut.state_q), 64'(IDLE));
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0608, 1'b0); tick(); clear_commits();
    rd(2'd2, v); chk("t5_exc_count", 64'(v), 64'd1);
    put(0, OP_JALR, 5'd1, 5'd2, 64'h8000_0700, 1'b0); tick(); clear_commits();
    cfg_write(2'd0, 32'h1E);
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0704, 1'b0); tick(); clear_commits();
    rd(2'd2, v); chk("t5_dis_count", 64'(v), 64'd1);
    chk("t5_dis_req", 64'(bus.cfi_exc_req_o), 64'd0);
    cfg_write(2'd0, 32'h1F);

    // Saturation at 0xFFFF, then asynchronous reset while reporting
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_count = 65535;
    put(0, OP_JALR, 5'd0, 5'd9, 64'h8000_0800, 1'b0); tick(); clear_commits();
    put(0, OP_ADD, 5'd2, 5'd2, 64'h8000_0804, 1'b0); tick(); clear_commits();
    rd(2'd2, v); chk("t6_sat_count", 64'(v), 64'hFFFF);
    chk("t6_req", 64'(bus.cfi_exc_req_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_exc_pc", bus.cfi_exc_pc_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized commit streams against the model
    cfg_write(2'd0, 32'h1F);
    for (int c = 0; c < 400; c++) begin
      clear_commits();
      n = $urandom_range(0, NP);
      for (int p = 0; p < n; p++) begin
        bus.commit_ack_i[p]   = 1'b1;
        bus.commit_instr_i[p] = rand_entry();
      end
      bus.cfi_exc_ack_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd0;
        bus.cfg_wdata_i = {23'd0,
                           ($urandom_range(0, 1) == 0) ? 5'd1 : 5'($urandom_range(0, 31)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
      end else if (r == 1) begin
        bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd2; bus.cfg_wdata_i = $urandom;
      end else if (r == 2) begin
        bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd1; bus.cfg_wdata_i = $urandom;
      end
      tick();
      bus.cfg_we_i = 1'b0;
    end
    clear_commits();
    bus.cfi_exc_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
